apb_interconnect: RTL and testbench

- 4-master x 4-slave APB crossbar. Each slave port has its own round-robin arbiter, so masters targeting different slaves transfer concurrently.
- Sits between APB masters (bridges/CPUs) and APB peripherals.
- Routes setup/access signals from the granted master to the decoded slave, and routes PRDATA/PREADY back.

---
 rtl/apb_interconnect_pkg.sv | 17 +
 rtl/apb_interconnect_if.sv | 25 ++
 rtl/apb_interconnect_rr_arbiter.sv | 73 +++++++
 rtl/apb_interconnect.sv | 90 +++++++++
 tb/tb_apb_interconnect.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/apb_interconnect_pkg.sv
// Shared sizing and address decode for the 4x4 APB crossbar.
package apb_ic_pkg;

   localparam int NUM_M  = 4;
   localparam int NUM_S  = 4;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int SEL_W  = $clog2(NUM_S);
   localparam int STRB_W = DW / 8;
   localparam int MID_W  = $clog2(NUM_M);

   // Top SEL_W address bits select the slave; every code maps to a real port.
   function automatic logic [SEL_W-1:0] decode_slave(input logic [AW-1:0] addr);
      return addr[AW-1 -: SEL_W];
   endfunction

endpackage

// File: rtl/apb_interconnect_if.sv
// Multi-port APB bundle; N parallel ports share one interface instance.
interface apb_ic_if #(
   parameter int N = 4
) ();

   logic [N-1:0]                          PSEL;
   logic [N-1:0]                          PENABLE;
   logic [N-1:0]                          PWRITE;
   logic [N-1:0][apb_ic_pkg::AW-1:0]      PADDR;
   logic [N-1:0][apb_ic_pkg::DW-1:0]      PWDATA;
   logic [N-1:0][apb_ic_pkg::STRB_W-1:0]  PSTRB;
   logic [N-1:0][apb_ic_pkg::DW-1:0]      PRDATA;
   logic [N-1:0]                          PREADY;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY
   );

endinterface

// File: rtl/apb_interconnect_rr_arbiter.sv
// Per-slave round-robin arbiter: holds a grant until the owner stops requesting.
module apb_rr_arbiter
   import apb_ic_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_M-1:0]  req_i,
   output logic [MID_W-1:0]  owner_o,
   output logic              valid_o,
   output logic              setup_seen_o
);

   logic [MID_W-1:0] owner_q, owner_d;
   logic             valid_q, valid_d;
   logic [MID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             setup_seen_q, setup_seen_d;
   logic             found;
   logic [MID_W-1:0] winner;
   logic [MID_W-1:0] idx;

   always_comb begin
      found  = 1'b0;
      winner = rr_ptr_q;
      idx    = '0;
      for (int i = 0; i < NUM_M; i++) begin
         idx = MID_W'((int'(rr_ptr_q) + i) % NUM_M);
         if (!found && req_i[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // A release leaves the slave idle for one cycle before re-arbitration.
   always_comb begin
      owner_d      = owner_q;
      valid_d      = valid_q;
      rr_ptr_d     = rr_ptr_q;
      setup_seen_d = setup_seen_q;
      if (valid_q) begin
         if (req_i[owner_q]) begin
            setup_seen_d = 1'b1;
         end else begin
            valid_d      = 1'b0;
            setup_seen_d = 1'b0;
         end
      end else if (found) begin
         valid_d      = 1'b1;
         owner_d      = winner;
         rr_ptr_d     = MID_W'((int'(winner) + 1) % NUM_M);
         setup_seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q      <= '0;
         valid_q      <= 1'b0;
         rr_ptr_q     <= '0;
         setup_seen_q <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         valid_q      <= valid_d;
         rr_ptr_q     <= rr_ptr_d;
         setup_seen_q <= setup_seen_d;
      end
   end

   assign owner_o      = owner_q;
   assign valid_o      = valid_q;
   assign setup_seen_o = setup_seen_q;

endmodule

// File: rtl/apb_interconnect.sv
// 4x4 APB crossbar: address decode, per-slave arbitration, forward and return muxing.
module apb_interconnect
   import apb_ic_pkg::*;
(
   input  logic              PCLK,
   input  logic              PRST,
   apb_ic_if.slave           m_if,
   apb_ic_if.master          s_if,
   output logic [NUM_M-1:0]  PGRANT
);

   logic [NUM_S-1:0][NUM_M-1:0]  req;
   logic [NUM_S-1:0][MID_W-1:0]  owner;
   logic [NUM_S-1:0]             valid;
   logic [NUM_S-1:0]             setup_seen;

   logic [NUM_S-1:0]             psel_s, penable_s, pwrite_s;
   logic [NUM_S-1:0][AW-1:0]     paddr_s;
   logic [NUM_S-1:0][DW-1:0]     pwdata_s;
   logic [NUM_S-1:0][STRB_W-1:0] pstrb_s;

   logic [NUM_M-1:0]             pready_m;
   logic [NUM_M-1:0][DW-1:0]     prdata_m;

   always_comb begin
      req = '0;
      for (int m = 0; m < NUM_M; m++) begin
         if (m_if.PSEL[m]) req[decode_slave(m_if.PADDR[m])][m] = 1'b1;
      end
   end

   for (genvar s = 0; s < NUM_S; s++) begin : g_arb
      apb_rr_arbiter u_arb (
         .clk_i        (PCLK),
         .rst_i        (PRST),
         .req_i        (req[s]),
         .owner_o      (owner[s]),
         .valid_o      (valid[s]),
         .setup_seen_o (setup_seen[s])
      );
   end

   // PENABLE is held back until the slave has had one setup cycle.
   always_comb begin
      psel_s    = '0;
      penable_s = '0;
      pwrite_s  = '0;
      paddr_s   = '0;
      pwdata_s  = '0;
      pstrb_s   = '0;
      for (int s = 0; s < NUM_S; s++) begin
         if (valid[s]) begin
            psel_s[s]    = 1'b1;
            penable_s[s] = m_if.PENABLE[owner[s]] & setup_seen[s];
            pwrite_s[s]  = m_if.PWRITE[owner[s]];
            paddr_s[s]   = m_if.PADDR[owner[s]];
            pwdata_s[s]  = m_if.PWDATA[owner[s]];
            pstrb_s[s]   = m_if.PSTRB[owner[s]];
         end
      end
   end

   assign s_if.PSEL    = psel_s;
   assign s_if.PENABLE = penable_s;
   assign s_if.PWRITE  = pwrite_s;
   assign s_if.PADDR   = paddr_s;
   assign s_if.PWDATA  = pwdata_s;
   assign s_if.PSTRB   = pstrb_s;

   always_comb begin
      PGRANT   = '0;
      pready_m = '0;
      prdata_m = '0;
      for (int m = 0; m < NUM_M; m++) begin
         for (int s = 0; s < NUM_S; s++) begin
            if (valid[s] && owner[s] == MID_W'(m)) begin
               PGRANT[m] = 1'b1;
               if (s_if.PREADY[s] && penable_s[s]) begin
                  pready_m[m] = 1'b1;
                  if (!pwrite_s[s]) prdata_m[m] = s_if.PRDATA[s];
               end
            end
         end
      end
   end

   assign m_if.PREADY = pready_m;
   assign m_if.PRDATA = prdata_m;

endmodule

// File: tb/tb_apb_interconnect.sv
// Directed bench for the APB crossbar with hand-computed expectations.
module tb_apb_interconnect;
   import apb_ic_pkg::*;

   logic             clk;
   logic             rst;
   logic [NUM_M-1:0] pgrant;
   int               checks;
   int               errors;

   apb_ic_if #(.N(NUM_M)) m_bus ();
   apb_ic_if #(.N(NUM_S)) s_bus ();

   apb_interconnect dut (
      .PCLK   (clk),
      .PRST   (rst),
      .m_if   (m_bus),
      .s_if   (s_bus),
      .PGRANT (pgrant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      m_bus.PSEL = '0;  m_bus.PENABLE = '0; m_bus.PWRITE = '0;
      m_bus.PADDR = '0; m_bus.PWDATA = '0;  m_bus.PSTRB = '0;
      s_bus.PRDATA = '0; s_bus.PREADY = '0;
      cyc(); cyc();
      chk("rst_pgrant", 64'(pgrant), 64'h0);
      chk("rst_psel_s", 64'(s_bus.PSEL), 64'h0);
      chk("rst_pready", 64'(m_bus.PREADY), 64'h0);
      rst = 1'b0;

      // master 2 write to slave 1
      cyc();
      m_bus.PSEL[2] = 1'b1; m_bus.PWRITE[2] = 1'b1; m_bus.PADDR[2] = 32'h7000_0003;
      m_bus.PWDATA[2] = 32'd10; m_bus.PSTRB[2] = 4'b0010;
      s_bus.PREADY[1] = 1'b1; s_bus.PRDATA[1] = 32'hDEAD;
      #1;
      chk("wr_latency_pgrant", 64'(pgrant), 64'h0);
      cyc();
      chk("wr_pgrant", 64'(pgrant), 64'b0100);
      chk("wr_psel_s", 64'(s_bus.PSEL), 64'b0010);
      chk("wr_pwrite_s", 64'(s_bus.PWRITE), 64'b0010);
      chk("wr_paddr_s1", 64'(s_bus.PADDR[1]), 64'h7000_0003);
      chk("wr_pwdata_s1", 64'(s_bus.PWDATA[1]), 64'd10);
      chk("wr_pstrb_s1", 64'(s_bus.PSTRB[1]), 64'b0010);
      chk("wr_paddr_s0_idle", 64'(s_bus.PADDR[0]), 64'h0);
      chk("wr_setup_penable_s", 64'(s_bus.PENABLE), 64'h0);
      chk("wr_setup_pready", 64'(m_bus.PREADY), 64'h0);
      cyc();
      m_bus.PENABLE[2] = 1'b1;
      #1;
      chk("wr_access_penable_s", 64'(s_bus.PENABLE), 64'b0010);
      chk("wr_access_pready", 64'(m_bus.PREADY), 64'b0100);
      chk("wr_access_prdata2", 64'(m_bus.PRDATA[2]), 64'h0);
      cyc();
      m_bus.PSEL[2] = 1'b0; m_bus.PENABLE[2] = 1'b0;
      #1;
      chk("wr_release_cycle_pgrant", 64'(pgrant), 64'b0100);
      cyc();
      chk("wr_idle_pgrant", 64'(pgrant), 64'h0);
      chk("wr_idle_psel_s", 64'(s_bus.PSEL), 64'h0);
      s_bus.PREADY[1] = 1'b0;

      // master 1 read from slave 3
      m_bus.PSEL[1] = 1'b1; m_bus.PWRITE[1] = 1'b0; m_bus.PADDR[1] = 32'hF000_0003;
      s_bus.PRDATA[3] = 32'd11; s_bus.PREADY[3] = 1'b1;
      cyc();
      chk("rd_pgrant", 64'(pgrant), 64'b0010);
      chk("rd_psel_s", 64'(s_bus.PSEL), 64'b1000);
      cyc();
      m_bus.PENABLE[1] = 1'b1;
      #1;
      chk("rd_prdata1", 64'(m_bus.PRDATA[1]), 64'd11);
      chk("rd_pready", 64'(m_bus.PREADY), 64'b0010);
      chk("rd_prdata0", 64'(m_bus.PRDATA[0]), 64'h0);
      chk("rd_prdata2", 64'(m_bus.PRDATA[2]), 64'h0);
      cyc();
      m_bus.PSEL[1] = 1'b0; m_bus.PENABLE[1] = 1'b0;
      s_bus.PREADY[3] = 1'b0;
      cyc();

      // contention on slave 1 right after reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      m_bus.PSEL[0] = 1'b1; m_bus.PADDR[0] = 32'h4000_0000;
      m_bus.PSEL[2] = 1'b1; m_bus.PADDR[2] = 32'h4000_0004; m_bus.PWRITE[2] = 1'b0;
      cyc();
      chk("arb_first_pgrant", 64'(pgrant), 64'b0001);
      chk("arb_first_paddr_s1", 64'(s_bus.PADDR[1]), 64'h4000_0000);
      cyc();
      chk("arb_hold_pgrant", 64'(pgrant), 64'b0001);
      cyc();
      m_bus.PSEL[0] = 1'b0;
      #1;
      chk("arb_release_cycle", 64'(pgrant), 64'b0001);
      cyc();
      chk("arb_gap_pgrant", 64'(pgrant), 64'h0);
      chk("arb_gap_psel_s", 64'(s_bus.PSEL), 64'h0);
      cyc();
      chk("arb_second_pgrant", 64'(pgrant), 64'b0100);
      chk("arb_second_paddr_s1", 64'(s_bus.PADDR[1]), 64'h4000_0004);
      m_bus.PSEL[2] = 1'b0;
      cyc(); cyc();

      // concurrent grants on different slaves
      m_bus.PSEL[0] = 1'b1; m_bus.PADDR[0] = 32'h0000_0010;
      m_bus.PSEL[3] = 1'b1; m_bus.PADDR[3] = 32'h8000_0020;
      cyc();
      chk("conc_pgrant", 64'(pgrant), 64'b1001);
      chk("conc_psel_s", 64'(s_bus.PSEL), 64'b0101);
      chk("conc_paddr_s0", 64'(s_bus.PADDR[0]), 64'h0000_0010);
      chk("conc_paddr_s2", 64'(s_bus.PADDR[2]), 64'h8000_0020);
      m_bus.PSEL[0] = 1'b0; m_bus.PSEL[3] = 1'b0;
      cyc(); cyc();

      // early PENABLE and wait states, master 1 on slave 2
      m_bus.PSEL[1] = 1'b1; m_bus.PENABLE[1] = 1'b1; m_bus.PADDR[1] = 32'h8000_0000;
      s_bus.PREADY[2] = 1'b0;
      cyc();
      chk("early_pgrant", 64'(pgrant), 64'b0010);
      chk("early_penable_s", 64'(s_bus.PENABLE), 64'h0);
      cyc();
      chk("wait1_penable_s", 64'(s_bus.PENABLE), 64'b0100);
      chk("wait1_pready", 64'(m_bus.PREADY), 64'h0);
      cyc();
      chk("wait2_pready", 64'(m_bus.PREADY), 64'h0);
      chk("wait2_pgrant", 64'(pgrant), 64'b0010);
      cyc();
      s_bus.PREADY[2] = 1'b1;
      #1;
      chk("wait_done_pready", 64'(m_bus.PREADY), 64'b0010);

      // reset in the middle of the access
      cyc();
      rst = 1'b1;
      cyc();
      chk("midrst_psel_s", 64'(s_bus.PSEL), 64'h0);
      chk("midrst_pgrant", 64'(pgrant), 64'h0);
      chk("midrst_pready", 64'(m_bus.PREADY), 64'h0);
      rst = 1'b0;
      m_bus.PSEL[1] = 1'b0; m_bus.PENABLE[1] = 1'b0;
      m_bus.PSEL[0] = 1'b1; m_bus.PADDR[0] = 32'h8000_0040;
      m_bus.PSEL[2] = 1'b1; m_bus.PADDR[2] = 32'h8000_0080;
      cyc();
      chk("postrst_pgrant", 64'(pgrant), 64'b0001);
      chk("postrst_paddr_s2", 64'(s_bus.PADDR[2]), 64'h8000_0040);
      m_bus.PSEL = '0;
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
